logic_unit_pipe: RTL

LOGIC_UNIT_PIPE -- requirements
Module: logic_unit_pipe

---
 rtl/logic_unit_pkg.sv | 24 ++
 rtl/logic_op.sv | 32 +++
 rtl/logic_unit_pipe.sv | 92 +++++++++
 3 files changed

// File: rtl/logic_unit_pkg.sv
// rtl/logic_unit_pkg.sv - shared constants and types for the logic unit pipeline
// Contents:
//   OP_WIDTH      width of the operation select field
//   OP_AND..OP_PASS_A  operation encodings
//   lu_state_e    result register occupancy (EMPTY / FULL)
package logic_unit_pkg;

    localparam int OP_WIDTH = 3;

    localparam logic [OP_WIDTH-1:0] OP_AND    = 3'b000;
    localparam logic [OP_WIDTH-1:0] OP_OR     = 3'b001;
    localparam logic [OP_WIDTH-1:0] OP_NAND   = 3'b010;
    localparam logic [OP_WIDTH-1:0] OP_NOR    = 3'b011;
    localparam logic [OP_WIDTH-1:0] OP_XOR    = 3'b100;
    localparam logic [OP_WIDTH-1:0] OP_XNOR   = 3'b101;
    localparam logic [OP_WIDTH-1:0] OP_NOT_A  = 3'b110;
    localparam logic [OP_WIDTH-1:0] OP_PASS_A = 3'b111;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } lu_state_e;

endpackage

// File: rtl/logic_op.sv
// rtl/logic_op.sv - combinational bitwise operation selector
// Ports:
//   a, b     [WIDTH-1:0]    operands
//   op       [OP_WIDTH-1:0] operation select
//   result   [WIDTH-1:0]    bitwise result of op applied to a, b
module logic_op
    import logic_unit_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0]    a,
    input  logic [WIDTH-1:0]    b,
    input  logic [OP_WIDTH-1:0] op,
    output logic [WIDTH-1:0]    result
);

    always_comb begin
        result = '0;
        case (op)
            OP_AND:    result = a & b;
            OP_OR:     result = a | b;
            OP_NAND:   result = ~(a & b);
            OP_NOR:    result = ~(a | b);
            OP_XOR:    result = a ^ b;
            OP_XNOR:   result = ~(a ^ b);
            OP_NOT_A:  result = ~a;
            OP_PASS_A: result = a;
            default:   result = '0;
        endcase
    end

endmodule

// File: rtl/logic_unit_pipe.sv
// rtl/logic_unit_pipe.sv - single-stage registered logic unit with valid/ready handshake
// Optional feature macro: LOGIC_UNIT_STATS_EN (enables the saturating ops_count counter;
// when undefined ops_count is tied to 0 and no counter flops exist).
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   in_valid / in_ready  input handshake for a, b, op
//   a, b [WIDTH-1:0]     operands; op [2:0] operation select
//   y [WIDTH-1:0]        registered result; y_zero high when y is all zeros
//   out_valid/out_ready  output handshake
//   ops_count            accepted-input count, saturating at all ones
module logic_unit_pipe
    import logic_unit_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic [OP_WIDTH-1:0]  op,
    output logic [WIDTH-1:0]     y,
    output logic                 y_zero,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [CNT_WIDTH-1:0] ops_count
);

    lu_state_e        state_q;
    logic [WIDTH-1:0] y_q;
    logic [WIDTH-1:0] y_d;
    logic             zero_q;
    logic             zero_d;
    logic             accept;
    logic             drain;

    logic_op #(.WIDTH(WIDTH)) u_logic_op (
        .a      (a),
        .b      (b),
        .op     (op),
        .result (y_d)
    );

    // Zero flag is derived from the very value being loaded so the pair stays coherent.
    assign zero_d = (y_d == '0);

    assign out_valid = (state_q == ST_FULL);
    assign in_ready  = !out_valid || out_ready;
    assign accept    = in_valid && in_ready;
    assign drain     = out_valid && out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_EMPTY;
            y_q     <= '0;
            zero_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_EMPTY: if (accept) state_q <= ST_FULL;
                ST_FULL:  if (drain && !accept) state_q <= ST_EMPTY;
                default:  state_q <= ST_EMPTY;
            endcase
            // Result only moves on accept; a drain alone leaves the stale value in place.
            if (accept) begin
                y_q    <= y_d;
                zero_q <= zero_d;
            end
        end
    end

    assign y      = y_q;
    assign y_zero = zero_q;

`ifdef LOGIC_UNIT_STATS_EN
    logic [CNT_WIDTH-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (accept && (cnt_q != {CNT_WIDTH{1'b1}})) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign ops_count = cnt_q;
`else
    assign ops_count = '0;
`endif

endmodule
